// File: rtl/fp_mul_arbiter.sv
// Two-requester front end sharing one IEEE-754 single-precision multiplier; result valid CALC_CYCLES edges after accept.
// Backpressure: one operation in flight; req_ready low outside IDLE, result held in RESP until rsp_ready.

module fp_multiplier (
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic [31:0] out
);
   logic              sgn;
   logic [7:0]        e1, e2;
   logic [22:0]       f1, f2;
   logic              nan1, nan2, inf1, inf2, zero1, zero2;
   logic [47:0]       prod;
   logic [23:0]       mant;
   logic              grd, sticky, rnd;
   logic [24:0]       mant_r;
   logic signed [9:0] exp_v;

   assign sgn   = in1[31] ^ in2[31];
   assign e1    = in1[30:23];
   assign e2    = in2[30:23];
   assign f1    = in1[22:0];
   assign f2    = in2[22:0];
   assign nan1  = (e1 == 8'hFF) && (f1 != 23'd0);
   assign nan2  = (e2 == 8'hFF) && (f2 != 23'd0);
   assign inf1  = (e1 == 8'hFF) && (f1 == 23'd0);
   assign inf2  = (e2 == 8'hFF) && (f2 == 23'd0);
   // Subnormal inputs are flushed to zero.
   assign zero1 = (e1 == 8'd0);
   assign zero2 = (e2 == 8'd0);
   assign prod  = 48'({1'b1, f1}) * 48'({1'b1, f2});

   always_comb begin
      if (prod[47]) begin
         mant   = prod[47:24];
         grd    = prod[23];
         sticky = |prod[22:0];
      end else begin
         mant   = prod[46:23];
         grd    = prod[22];
         sticky = |prod[21:0];
      end
      rnd    = grd & (sticky | mant[0]);
      mant_r = {1'b0, mant} + 25'(rnd);
      exp_v  = $signed({2'b00, e1}) + $signed({2'b00, e2}) - 10'sd127
               + $signed({9'd0, prod[47]}) + $signed({9'd0, mant_r[24]});

      if (nan1 || nan2 || (inf1 && zero2) || (zero1 && inf2)) begin
         out = 32'h7FC0_0000;
      end else if (inf1 || inf2) begin
         out = {sgn, 8'hFF, 23'd0};
      end else if (zero1 || zero2) begin
         out = {sgn, 31'd0};
      end else if (exp_v >= 10'sd255) begin
         out = {sgn, 8'hFF, 23'd0};
      end else if (exp_v <= 10'sd0) begin
         out = {sgn, 31'd0};
      end else begin
         out = {sgn, exp_v[7:0], (mant_r[24] ? mant_r[23:1] : mant_r[22:0])};
      end
   end
endmodule

module fp_mul_arbiter #(
   parameter int unsigned CALC_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t      state_q, state_d;
   logic        ptr_q, ptr_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_id_q, rsp_id_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        busy_q, busy_d;
   logic        grant1, idle_ok;
   logic [31:0] mul_out;

   fp_multiplier u_mul (.in1(a_q), .in2(b_q), .out(mul_out));

   // Pointer only breaks ties; a lone requester always wins.
   assign grant1     = req1_valid & (~req0_valid | ptr_q);
   assign idle_ok    = (state_q == IDLE) & ~rst;
   assign req0_ready = idle_ok & req0_valid & ~grant1;
   assign req1_ready = idle_ok & grant1;

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_q;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      rsp_valid_d = rsp_valid_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            if (req0_ready || req1_ready) begin
               a_d      = grant1 ? req1_a : req0_a;
               b_d      = grant1 ? req1_b : req0_b;
               rsp_id_d = grant1;
               ptr_d    = ~grant1;
               cnt_d    = 4'(CALC_CYCLES - 1);
               state_d  = CALC;
               busy_d   = 1'b1;
            end
         end
         CALC: begin
            if (cnt_q == 4'd0) begin
               rsp_data_d  = mul_out;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         cnt_q       <= 4'd0;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         rsp_data_q  <= 32'd0;
         rsp_id_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a response scoreboard and a CALC_CYCLES=4 latency instance.

module tb_fp_mul_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        r0v, r1v, r0rdy, r1rdy, rv, rrdy, rid, busy;
   logic [31:0] r0a, r0b, r1a, r1b, rdata;
   logic        q0v, q1v, q0rdy, q1rdy, qv, qrdy, qid, qbusy;
   logic [31:0] qdata;

   typedef struct packed {logic id; logic [31:0] data;} exp_t;
   exp_t sbq[$];

   int   total = 0;
   int   bad = 0;
   logic model_ptr = 1'b0;
   logic last_hs0, last_hs1;
   logic smp_rdy0, smp_rdy1, smp_busy, smp_rv, smp_id;
   logic [31:0] smp_data;
   logic [31:0] ta [10];
   logic [31:0] tb [10];

   always #5 clk = ~clk;

   fp_mul_arbiter #(.CALC_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .req0_valid(r0v), .req1_valid(r1v),
      .req0_ready(r0rdy), .req1_ready(r1rdy), .req0_a(r0a), .req0_b(r0b),
      .req1_a(r1a), .req1_b(r1b), .rsp_valid(rv), .rsp_ready(rrdy),
      .rsp_id(rid), .rsp_data(rdata), .busy(busy));

   fp_mul_arbiter #(.CALC_CYCLES(4)) dut4 (
      .clk(clk), .rst(rst), .req0_valid(q0v), .req1_valid(q1v),
      .req0_ready(q0rdy), .req1_ready(q1rdy), .req0_a(r0a), .req0_b(r0b),
      .req1_a(r1a), .req1_b(r1b), .rsp_valid(qv), .rsp_ready(qrdy),
      .rsp_id(qid), .rsp_data(qdata), .busy(qbusy));

   function automatic logic [31:0] exp_mul(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h4000_0000, 32'h4040_0000}: return 32'h40C0_0000;
         {32'h3FC0_0000, 32'hC080_0000}: return 32'hC0C0_0000;
         {32'h3FC0_0000, 32'h3FC0_0000}: return 32'h4010_0000;
         {32'h3F80_0000, 32'hC080_0000}: return 32'hC080_0000;
         {32'h7F80_0000, 32'h4000_0000}: return 32'h7F80_0000;
         {32'h8000_0000, 32'h4040_0000}: return 32'h8000_0000;
         {32'h7FC0_0000, 32'h4000_0000}: return 32'h7FC0_0000;
         {32'h7F80_0000, 32'h0000_0000}: return 32'h7FC0_0000;
         {32'h7F00_0000, 32'h7F00_0000}: return 32'h7F80_0000;
         {32'h0080_0000, 32'h0080_0000}: return 32'h0000_0000;
         {32'h3F80_0001, 32'h3F80_0001}: return 32'h3F80_0002;
         {32'h3FC0_0001, 32'h3FC0_0001}: return 32'h4010_0002;
         {32'h3FFF_FFFF, 32'h3FFF_FFFF}: return 32'h407F_FFFE;
         default:                        return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock: sample just before the edge (inputs already settled), then step to the next negedge.
   task automatic cyc();
      logic g1;
      exp_t e, p;
      #1;
      smp_rdy0 = r0rdy; smp_rdy1 = r1rdy; smp_busy = busy;
      smp_rv = rv; smp_data = rdata; smp_id = rid;
      last_hs0 = r0v & r0rdy;
      last_hs1 = r1v & r1rdy;
      if (rst) begin
         chk("ready_in_rst", {30'd0, r1rdy, r0rdy}, 32'd0);
      end else begin
         if (busy) chk("ready_while_busy", {30'd0, r1rdy, r0rdy}, 32'd0);
         if (r0rdy || r1rdy) begin
            g1 = r1v & (~r0v | model_ptr);
            chk("grant", {30'd0, r1rdy, r0rdy}, g1 ? 32'd2 : 32'd1);
            e.id   = g1;
            e.data = g1 ? exp_mul(r1a, r1b) : exp_mul(r0a, r0b);
            sbq.push_back(e);
            model_ptr = ~g1;
         end
         if (rv && rrdy) begin
            chk("rsp_expected", {31'd0, sbq.size() > 0}, 32'd1);
            if (sbq.size() > 0) begin
               p = sbq.pop_front();
               chk("rsp_id", {31'd0, rid}, {31'd0, p.id});
               chk("rsp_data", rdata, p.data);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_hs(input int max);
      logic got = 1'b0;
      for (int c = 0; c < max && !got; c++) begin
         cyc();
         got = last_hs0 | last_hs1;
      end
      chk("hs_timeout", {31'd0, got}, 32'd1);
   endtask

   task automatic drain(input int max);
      logic done = 1'b0;
      for (int c = 0; c < max && !done; c++) begin
         cyc();
         done = (sbq.size() == 0) && !rv && !busy;
      end
      chk("drain_timeout", {31'd0, done}, 32'd1);
   endtask

   // Both requesters raise valid; each drops it once accepted.
   task automatic serve2();
      int n = 0;
      for (int c = 0; c < 40 && n < 2; c++) begin
         cyc();
         if (last_hs0) begin r0v = 1'b0; n++; end
         if (last_hs1) begin r1v = 1'b0; n++; end
      end
      chk("serve2_count", n, 32'd2);
      drain(20);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      sbq.delete();
      model_ptr = 1'b0;
   endtask

   initial begin
      ta = '{32'h3F80_0000, 32'h7F80_0000, 32'h8000_0000, 32'h7FC0_0000, 32'h7F80_0000,
             32'h7F00_0000, 32'h0080_0000, 32'h3F80_0001, 32'h3FC0_0001, 32'h3FFF_FFFF};
      tb = '{32'hC080_0000, 32'h4000_0000, 32'h4040_0000, 32'h4000_0000, 32'h0000_0000,
             32'h7F00_0000, 32'h0080_0000, 32'h3F80_0001, 32'h3FC0_0001, 32'h3FFF_FFFF};
      rst = 1'b1; r0v = 1'b1; r1v = 1'b0; rrdy = 1'b1;
      r0a = 32'h4000_0000; r0b = 32'h4040_0000; r1a = 32'd0; r1b = 32'd0;
      q0v = 1'b0; q1v = 1'b0; qrdy = 1'b1;

      // Reset state
      cyc();
      cyc();
      chk("rst_rsp_valid", {31'd0, rv}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_data", rdata, 32'd0);
      chk("rst_rsp_id", {31'd0, rid}, 32'd0);
      rst = 1'b0;

      // Single request, one-cycle latency
      wait_hs(5);
      chk("single_hs0", {31'd0, last_hs0}, 32'd1);
      r0v = 1'b0;
      cyc();
      chk("single_calc_rv", {31'd0, smp_rv}, 32'd0);
      chk("single_calc_busy", {31'd0, smp_busy}, 32'd1);
      cyc();
      chk("single_resp_rv", {31'd0, smp_rv}, 32'd1);
      chk("single_resp_data", smp_data, 32'h40C0_0000);
      chk("single_idle_busy", {31'd0, busy}, 32'd0);
      chk("single_idle_rv", {31'd0, rv}, 32'd0);

      // Contention right after reset: requester 0 first
      do_reset();
      r0v = 1'b1; r1v = 1'b1;
      r1a = 32'h3FC0_0000; r1b = 32'hC080_0000;
      serve2();

      // Fairness over six back-to-back operations
      begin
         int n = 0;
         r0v = 1'b1; r1v = 1'b1;
         for (int c = 0; c < 60 && n < 6; c++) begin
            cyc();
            chk("fair_busy", {31'd0, smp_busy}, {31'd0, !(smp_rdy0 | smp_rdy1)});
            if (last_hs0 | last_hs1) begin
               chk("fair_grant", {31'd0, last_hs1}, n % 2);
               n++;
            end
         end
         r0v = 1'b0; r1v = 1'b0;
         chk("fair_count", n, 32'd6);
         drain(20);
      end

      // Backpressure in RESP with operands changing underneath
      rrdy = 1'b0;
      r0a = 32'h3FC0_0000; r0b = 32'h3FC0_0000; r0v = 1'b1;
      wait_hs(5);
      cyc();
      for (int i = 0; i < 5; i++) begin
         r0a = 32'h3F80_0000 + i; r0b = 32'h4100_0000 - i;
         cyc();
         chk("bp_rv", {31'd0, smp_rv}, 32'd1);
         chk("bp_data", smp_data, 32'h4010_0000);
         chk("bp_id", {31'd0, smp_id}, 32'd0);
         chk("bp_ready", {30'd0, smp_rdy1, smp_rdy0}, 32'd0);
      end
      r0a = 32'h4000_0000; r0b = 32'h4040_0000; rrdy = 1'b1;
      cyc();
      cyc();
      chk("bp_idle_next", {31'd0, last_hs0}, 32'd1);
      r0v = 1'b0;
      drain(20);

      // Special values and rounding, alternating lone requesters
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) begin r0a = ta[i]; r0b = tb[i]; r0v = 1'b1; end
         else begin r1a = ta[i]; r1b = tb[i]; r1v = 1'b1; end
         wait_hs(5);
         r0v = 1'b0; r1v = 1'b0;
         drain(20);
      end

      // Reset during CALC discards the operation and clears the pointer
      r0a = 32'h4000_0000; r0b = 32'h4040_0000; r0v = 1'b1;
      wait_hs(5);
      rst = 1'b1;
      cyc();
      chk("mid_rv", {31'd0, rv}, 32'd0);
      chk("mid_busy", {31'd0, busy}, 32'd0);
      chk("mid_data", rdata, 32'd0);
      rst = 1'b0;
      sbq.delete();
      model_ptr = 1'b0;
      r0a = 32'h3FC0_0000; r0b = 32'h3FC0_0000;
      r1a = 32'h4000_0000; r1b = 32'h4040_0000;
      r0v = 1'b1; r1v = 1'b1;
      serve2();

      // CALC_CYCLES=4 instance: result exactly four edges after the accept edge
      begin
         logic hs = 1'b0;
         int   lat = 0;
         r0a = 32'h4000_0000; r0b = 32'h4040_0000; q0v = 1'b1;
         for (int c = 0; c < 10 && !hs; c++) begin
            #1;
            hs = q0rdy;
            @(negedge clk);
         end
         chk("d4_hs", {31'd0, hs}, 32'd1);
         q0v = 1'b0;
         r0a = 32'h3F80_0000; r0b = 32'h3F80_0000;
         for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(posedge clk);
            #1;
            if (qv) lat = c;
         end
         chk("d4_latency", lat, 32'd4);
         chk("d4_data", qdata, 32'h40C0_0000);
         chk("d4_id", {31'd0, qid}, 32'd0);
         @(negedge clk);
         @(negedge clk);
         chk("d4_idle_rv", {31'd0, qv}, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 Parameter: CALC_CYCLES, default 1, number of cycles operands are held on the multiplier before the result is captured; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_valid / req1_valid  input  1 each  requester 0/1 has an operand pair pending.
REQ-005 req0_ready / req1_ready  output  1 each  requester 0/1 operands accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  32 each  IEEE-754 single-precision operands.
REQ-007 rsp_valid  output  1  result available.
REQ-008 rsp_ready  input  1  consumer accepts the result.
REQ-009 rsp_id  output  1  requester index the result belongs to.
REQ-010 rsp_data  output  32  product of the granted operand pair.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The block SHALL instantiate exactly one fp_multiplier (ports in1, in2, out) and share it between the two requesters.
REQ-013 The FSM SHALL have states IDLE, CALC, RESP.
REQ-014 IDLE: req_ready SHALL be high only for the granted requester, combinationally, when that requester's req_valid is high; the other req_ready SHALL be 0.
REQ-015 Grant: if only one requester's req_valid is high, it is granted; if both are high, the requester indicated by a 1-bit round-robin pointer is granted.
REQ-016 On an IDLE handshake (req_valid & req_ready), the block SHALL latch both operands and the requester index, set the pointer to the other requester, load the cycle counter with CALC_CYCLES-1, and enter CALC.
REQ-017 CALC: the latched operands SHALL drive fp_multiplier in1/in2; the counter SHALL decrement each cycle; when the counter reads 0, the block SHALL register out into rsp_data and enter RESP on the same edge.
REQ-018 Latency: for a handshake at edge k, rsp_valid SHALL be high starting immediately after edge k+CALC_CYCLES.
REQ-019 RESP: rsp_valid=1, and rsp_data and rsp_id SHALL stay stable until rsp_ready is sampled high; on that edge the block SHALL enter IDLE.
REQ-020 Both req_ready outputs SHALL be 0 in CALC and RESP; new requests wait and SHALL NOT be dropped (requester holds valid).
REQ-021 Throughput: at most one operation per CALC_CYCLES+2 cycles; no back-to-back acceptance without passing through IDLE.
REQ-022 Operand changes on req*_a/b after the handshake SHALL NOT affect rsp_data.
REQ-023 The pointer SHALL change only on an accepted handshake; a lone requester is granted even if the pointer favours the other.
REQ-024 The block SHALL perform no arithmetic of its own; rsp_data equals fp_multiplier output for the latched operands bit-for-bit (special values passed through unchanged).

Reset
REQ-025 When rst is high at a rising edge, the FSM SHALL enter IDLE, the pointer SHALL be 0 (requester 0 favoured), the counter, rsp_data, and rsp_id SHALL be 0, and rsp_valid and busy SHALL be 0.
REQ-026 Reset asserted in CALC or RESP SHALL abort the operation; the in-flight result is discarded and never presented.
REQ-027 req_ready outputs SHALL be 0 during any cycle rst is high.

Verification
REQ-028 Single request: CALC_CYCLES=1; req0 a=0x40000000 (2.0), b=0x40400000 (3.0), rsp_ready=1 -> rsp_valid one cycle after handshake, rsp_data=0x40C00000, rsp_id=0, back to IDLE next edge.
REQ-029 Contention after reset: both valid, req0 2.0*3.0, req1 a=0x3FC00000 (1.5), b=0xC0800000 (-4.0) -> req0 served first (0x40C00000, id 0), then req1 (0xC0C00000, id 1).
REQ-030 Fairness: both valid continuously for 6 operations -> grants alternate 0,1,0,1,0,1; busy low only in the IDLE cycle between operations.
REQ-031 Backpressure: hold rsp_ready=0 for 5 cycles in RESP while changing req0 operands -> rsp_valid, rsp_data, rsp_id stable; both req_ready stay 0; release -> IDLE next edge.
REQ-032 Latency parameter: CALC_CYCLES=4 -> rsp_valid rises exactly 4 edges after the handshake edge; result identical to the CALC_CYCLES=1 result.
REQ-033 Reset mid-op: assert rst in CALC -> next cycle IDLE, rsp_valid=0, pointer=0; the aborted result never appears; a fresh request completes normally.
